cavlc_enc_ctrl: RTL and testbench

Control FSM for the CAVLC block encoder, the write-side counterpart of the decoder control FSM. Per 4x4 (or chroma) block, it sequences the sub-encoders in bitstream order: coeff_token, trailing-ones signs, levels, total_zeros, run_before. It multiplexes their codewords onto a single ready/valid write port into the bit packer and pulses BlockDone when the last bit of the block has been accepted.

---
 rtl/cavlc_enc_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cavlc_enc_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_enc_ctrl.sv
// -----------------------------------------------------------------------------
// cavlc_enc_ctrl
// Control FSM for the CAVLC block encoder. For each 4x4 / chroma block it
// walks the sub-encoders in bitstream order (coeff_token, trailing-ones
// signs, levels, total_zeros, run_before) and funnels their codewords onto
// one ready/valid write port into the bit packer. BlockDone pulses in the
// cycle after the last word of the block has been accepted.
//
// Optional feature macro: CAVLC_ENC_BITCOUNT_EN
//   When defined, adds output BlockBits[9:0]: the saturating sum of PackLen
//   over all accepted writes of the current block.
//
// Ports:
//   Clk, nReset                       clock, async active-low reset
//   BlockValid / BlockAccept          block-start handshake
//   TotalCoeff, TrailingOnes,
//   TotalZeros, T1Signs               block parameters, sampled on accept
//   CoeffTokenBits/Len                coeff_token codeword
//   TotalZerosBits/Len                total_zeros codeword
//   LevelValid/Last/Bits/Len, LevelReady   level encoder stream
//   RunValid/Last/Bits/Len, RunReady       run_before encoder stream
//   LevelEncodeEnable, RunEncodeEnable     high while in that state
//   PackValid/Bits/Len, PackReady     packer write port (right-aligned, MSB first)
//   BlockDone                         registered one-cycle end-of-block pulse
// -----------------------------------------------------------------------------
module cavlc_enc_ctrl #(
    parameter int MAX_COEFF = 16,
    parameter int CODE_W    = 16
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              BlockValid,
    output logic              BlockAccept,
    input  logic [4:0]        TotalCoeff,
    input  logic [1:0]        TrailingOnes,
    input  logic [3:0]        TotalZeros,
    input  logic [2:0]        T1Signs,
    input  logic [CODE_W-1:0] CoeffTokenBits,
    input  logic [4:0]        CoeffTokenLen,
    input  logic [CODE_W-1:0] TotalZerosBits,
    input  logic [4:0]        TotalZerosLen,
    input  logic              LevelValid,
    input  logic              LevelLast,
    input  logic [CODE_W-1:0] LevelBits,
    input  logic [4:0]        LevelLen,
    output logic              LevelReady,
    input  logic              RunValid,
    input  logic              RunLast,
    input  logic [CODE_W-1:0] RunBits,
    input  logic [4:0]        RunLen,
    output logic              RunReady,
    output logic              LevelEncodeEnable,
    output logic              RunEncodeEnable,
    output logic              PackValid,
    output logic [CODE_W-1:0] PackBits,
    output logic [4:0]        PackLen,
    input  logic              PackReady,
    output logic              BlockDone
`ifdef CAVLC_ENC_BITCOUNT_EN
    ,
    output logic [9:0]        BlockBits
`endif
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] COEFF_TOKEN = 3'd1;
    localparam logic [2:0] T1_SIGNS    = 3'd2;
    localparam logic [2:0] LEVEL_ENC   = 3'd3;
    localparam logic [2:0] TOTAL_ZEROS = 3'd4;
    localparam logic [2:0] RUN_BEFORE  = 3'd5;
    localparam logic [2:0] DONE        = 3'd6;

    localparam logic [5:0] MAX_COEFF_C = 6'(MAX_COEFF);

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic [4:0]        tc_r;
    logic [1:0]        t1_r;
    logic [3:0]        tz_r;
    logic [2:0]        sign_r;
    logic              done_r;

    logic              accept_s;
    logic [1:0]        t1_clamp_s;
    logic [2:0]        sign_mask_s;
    logic [2:0]        tz_check_s;
    logic              raw_valid_s;
    logic [CODE_W-1:0] raw_bits_s;
    logic [4:0]        raw_len_s;
    logic              advance_s;

    // Block handshake and trailing-ones clamp (TrailingOnes never exceeds TotalCoeff).
    always_comb begin
        BlockAccept = (state_r == IDLE) || (state_r == DONE);
        accept_s    = BlockAccept && BlockValid;
        if ({3'b000, TrailingOnes} > TotalCoeff) begin
            t1_clamp_s = TotalCoeff[1:0];
        end else begin
            t1_clamp_s = TrailingOnes;
        end
    end

    // Sign mask keeps only the TrailingOnes least significant sign bits.
    always_comb begin
        case (t1_r)
            2'd0:    sign_mask_s = 3'b000;
            2'd1:    sign_mask_s = 3'b001;
            2'd2:    sign_mask_s = 3'b011;
            2'd3:    sign_mask_s = 3'b111;
            default: sign_mask_s = 3'b000;
        endcase
    end

    // Destination after signs/levels: total_zeros is omitted for a full block.
    always_comb begin
        if ({1'b0, tc_r} < MAX_COEFF_C) begin
            tz_check_s = TOTAL_ZEROS;
        end else begin
            tz_check_s = DONE;
        end
    end

    // Source mux: select the codeword offered by the current state.
    always_comb begin
        raw_valid_s = 1'b0;
        raw_bits_s  = {CODE_W{1'b0}};
        raw_len_s   = 5'd0;
        case (state_r)
            COEFF_TOKEN: begin
                raw_valid_s = 1'b1;
                raw_bits_s  = CoeffTokenBits;
                raw_len_s   = CoeffTokenLen;
            end
            T1_SIGNS: begin
                raw_valid_s = 1'b1;
                raw_bits_s  = {{(CODE_W-3){1'b0}}, sign_r & sign_mask_s};
                raw_len_s   = {3'b000, t1_r};
            end
            LEVEL_ENC: begin
                raw_valid_s = LevelValid;
                raw_bits_s  = LevelBits;
                raw_len_s   = LevelLen;
            end
            TOTAL_ZEROS: begin
                raw_valid_s = 1'b1;
                raw_bits_s  = TotalZerosBits;
                raw_len_s   = TotalZerosLen;
            end
            RUN_BEFORE: begin
                raw_valid_s = RunValid;
                raw_bits_s  = RunBits;
                raw_len_s   = RunLen;
            end
            default: begin
                raw_valid_s = 1'b0;
                raw_bits_s  = {CODE_W{1'b0}};
                raw_len_s   = 5'd0;
            end
        endcase
    end

    // Packer port; zero-length words never reach the packer but still advance.
    always_comb begin
        PackValid         = raw_valid_s && (raw_len_s != 5'd0);
        PackBits          = raw_bits_s;
        PackLen           = raw_len_s;
        advance_s         = raw_valid_s && ((raw_len_s == 5'd0) || PackReady);
        LevelEncodeEnable = (state_r == LEVEL_ENC);
        RunEncodeEnable   = (state_r == RUN_BEFORE);
        LevelReady        = LevelEncodeEnable && ((LevelLen == 5'd0) || PackReady);
        RunReady          = RunEncodeEnable && ((RunLen == 5'd0) || PackReady);
        BlockDone         = done_r;
    end

    // Next-state logic in bitstream order.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = COEFF_TOKEN;
                else          state_next_s = IDLE;
            end
            COEFF_TOKEN: begin
                if (!advance_s)           state_next_s = COEFF_TOKEN;
                else if (tc_r == 5'd0)    state_next_s = DONE;
                else if (t1_r != 2'd0)    state_next_s = T1_SIGNS;
                else                      state_next_s = LEVEL_ENC;
            end
            T1_SIGNS: begin
                if (!advance_s)                  state_next_s = T1_SIGNS;
                else if (tc_r > {3'b000, t1_r})  state_next_s = LEVEL_ENC;
                else                             state_next_s = tz_check_s;
            end
            LEVEL_ENC: begin
                if (advance_s && LevelLast) state_next_s = tz_check_s;
                else                        state_next_s = LEVEL_ENC;
            end
            TOTAL_ZEROS: begin
                if (!advance_s)                               state_next_s = TOTAL_ZEROS;
                else if ((tz_r != 4'd0) && (tc_r > 5'd1))     state_next_s = RUN_BEFORE;
                else                                          state_next_s = DONE;
            end
            RUN_BEFORE: begin
                if (advance_s && RunLast) state_next_s = DONE;
                else                      state_next_s = RUN_BEFORE;
            end
            DONE: begin
                if (accept_s) state_next_s = COEFF_TOKEN;
                else          state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register, latched block parameters and BlockDone pulse.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= IDLE;
            tc_r    <= 5'd0;
            t1_r    <= 2'd0;
            tz_r    <= 4'd0;
            sign_r  <= 3'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_next_s == DONE);
            if (accept_s) begin
                tc_r   <= TotalCoeff;
                t1_r   <= t1_clamp_s;
                tz_r   <= TotalZeros;
                sign_r <= T1Signs;
            end
        end
    end

`ifdef CAVLC_ENC_BITCOUNT_EN
    logic [9:0]  bits_r;
    logic [10:0] bits_sum_s;

    // Candidate running sum including the word being accepted now.
    always_comb begin
        bits_sum_s = {1'b0, bits_r} + {6'd0, PackLen};
    end

    // Per-block bit counter: cleared on accept, saturating at 1023.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bits_r <= 10'd0;
        end else if (accept_s) begin
            bits_r <= 10'd0;
        end else if (PackValid && PackReady) begin
            bits_r <= (bits_sum_s > 11'd1023) ? 10'd1023 : bits_sum_s[9:0];
        end else begin
            bits_r <= bits_r;
        end
    end

    assign BlockBits = bits_r;
`endif

endmodule

// File: tb/tb_cavlc_enc_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cavlc_enc_ctrl: table of single-block vectors plus directed
// sequences (stalling packer, back-to-back blocks, MAX_COEFF=4 instance,
// reset in LEVEL_ENC). Expected packer words are queued when a block is
// started and popped as the DUT hands them to the packer.
// -----------------------------------------------------------------------------
module tb_cavlc_enc_ctrl;

    typedef struct packed {
        logic [15:0] bits;
        logic [4:0]  len;
    } word_t;

    typedef struct {
        logic [4:0]  tc;
        logic [1:0]  t1;
        logic [3:0]  tz;
        logic [2:0]  signs;
        logic [15:0] ct_bits;
        logic [4:0]  ct_len;
        logic [15:0] tz_bits;
        logic [4:0]  tz_len;
        int          n_lvl;
        int          n_run;
        int          exp_words;
        int          exp_lat;
        int          exp_lvl;
        int          exp_run;
    } vec_t;

    logic        Clk;
    logic        nReset;
    logic        BlockValid, BlockAccept;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailingOnes;
    logic [3:0]  TotalZeros;
    logic [2:0]  T1Signs;
    logic [15:0] CoeffTokenBits, TotalZerosBits, LevelBits, RunBits, PackBits;
    logic [4:0]  CoeffTokenLen, TotalZerosLen, LevelLen, RunLen, PackLen;
    logic        LevelValid, LevelLast, LevelReady;
    logic        RunValid, RunLast, RunReady;
    logic        LevelEncodeEnable, RunEncodeEnable;
    logic        PackValid, PackReady, BlockDone;
    logic        d4_accept, d4_level_ready, d4_run_ready, d4_level_en, d4_run_en;
    logic        d4_pack_valid, d4_done;
    logic [15:0] d4_pack_bits;
    logic [4:0]  d4_pack_len;
`ifdef CAVLC_ENC_BITCOUNT_EN
    logic [9:0]  BlockBits, d4_block_bits;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    cavlc_enc_ctrl #(.MAX_COEFF(16), .CODE_W(16)) u_dut (
        .Clk(Clk), .nReset(nReset), .BlockValid(BlockValid), .BlockAccept(BlockAccept),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .TotalZeros(TotalZeros),
        .T1Signs(T1Signs), .CoeffTokenBits(CoeffTokenBits), .CoeffTokenLen(CoeffTokenLen),
        .TotalZerosBits(TotalZerosBits), .TotalZerosLen(TotalZerosLen),
        .LevelValid(LevelValid), .LevelLast(LevelLast), .LevelBits(LevelBits),
        .LevelLen(LevelLen), .LevelReady(LevelReady),
        .RunValid(RunValid), .RunLast(RunLast), .RunBits(RunBits), .RunLen(RunLen),
        .RunReady(RunReady), .LevelEncodeEnable(LevelEncodeEnable),
        .RunEncodeEnable(RunEncodeEnable), .PackValid(PackValid), .PackBits(PackBits),
        .PackLen(PackLen), .PackReady(PackReady), .BlockDone(BlockDone)
`ifdef CAVLC_ENC_BITCOUNT_EN
        , .BlockBits(BlockBits)
`endif
    );

    cavlc_enc_ctrl #(.MAX_COEFF(4), .CODE_W(16)) u_dut4 (
        .Clk(Clk), .nReset(nReset), .BlockValid(BlockValid), .BlockAccept(d4_accept),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .TotalZeros(TotalZeros),
        .T1Signs(T1Signs), .CoeffTokenBits(CoeffTokenBits), .CoeffTokenLen(CoeffTokenLen),
        .TotalZerosBits(TotalZerosBits), .TotalZerosLen(TotalZerosLen),
        .LevelValid(LevelValid), .LevelLast(LevelLast), .LevelBits(LevelBits),
        .LevelLen(LevelLen), .LevelReady(d4_level_ready),
        .RunValid(RunValid), .RunLast(RunLast), .RunBits(RunBits), .RunLen(RunLen),
        .RunReady(d4_run_ready), .LevelEncodeEnable(d4_level_en),
        .RunEncodeEnable(d4_run_en), .PackValid(d4_pack_valid), .PackBits(d4_pack_bits),
        .PackLen(d4_pack_len), .PackReady(PackReady), .BlockDone(d4_done)
`ifdef CAVLC_ENC_BITCOUNT_EN
        , .BlockBits(d4_block_bits)
`endif
    );

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    word_t d4_q[$];
    word_t lvl_w[24];
    word_t run_w[24];
    int    lvl_n, lvl_i, run_n, run_i;
    int    cyc, hs_cnt, done_cnt, acc_cnt, acc_cyc, done_cyc;
    int    lvl_seen, run_seen, b2b_hits, d4_hs_cnt, d4_done_cyc, exp_bits, d4_exp_bits;
    bit    hold_bv, toggle, d4_chk_en, stall_v;
    logic [15:0] stall_bits;
    logic [4:0]  stall_len;
    vec_t  tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_src();
        LevelValid = (lvl_i < lvl_n);
        LevelBits  = lvl_w[lvl_i].bits;
        LevelLen   = lvl_w[lvl_i].len;
        LevelLast  = (lvl_i == lvl_n - 1);
        RunValid   = (run_i < run_n);
        RunBits    = run_w[run_i].bits;
        RunLen     = run_w[run_i].len;
        RunLast    = (run_i == run_n - 1);
    endtask

    // One clock: sample/compare on the falling edge, update stimulus after the rising edge.
    task automatic tick();
        bit    lf, rf, af;
        word_t w;
        @(negedge Clk);
        if (PackValid && PackReady) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pack_extra: got bits=0x%0h len=%0d, required no write", PackBits, PackLen);
            end else begin
                w = exp_q.pop_front();
                chk("pack_bits", 32'(PackBits), 32'(w.bits));
                chk("pack_len", 32'(PackLen), 32'(w.len));
            end
        end
        if (stall_v) begin
            chk("stall_valid", 32'(PackValid), 32'd1);
            chk("stall_bits", 32'(PackBits), 32'(stall_bits));
            chk("stall_len", 32'(PackLen), 32'(stall_len));
        end
        stall_v    = PackValid && !PackReady;
        stall_bits = PackBits;
        stall_len  = PackLen;
        if (LevelReady && !LevelEncodeEnable) chk("level_ready_gate", 32'(LevelReady), 32'd0);
        if (RunReady && !RunEncodeEnable)     chk("run_ready_gate", 32'(RunReady), 32'd0);
        if (LevelEncodeEnable) lvl_seen++;
        if (RunEncodeEnable)   run_seen++;
        if (BlockDone) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef CAVLC_ENC_BITCOUNT_EN
            chk("block_bits", 32'(BlockBits), 32'((exp_bits > 1023) ? 1023 : exp_bits));
`endif
        end
        if (d4_chk_en) begin
            if (d4_pack_valid && PackReady) begin
                d4_hs_cnt++;
                if (d4_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL d4_pack_extra: got len=%0d, required no write", d4_pack_len);
                end else begin
                    w = d4_q.pop_front();
                    chk("d4_pack_bits", 32'(d4_pack_bits), 32'(w.bits));
                    chk("d4_pack_len", 32'(d4_pack_len), 32'(w.len));
                end
            end
            if (d4_level_ready && !d4_level_en) chk("d4_level_gate", 32'(d4_level_ready), 32'd0);
            if (d4_run_ready && !d4_run_en)     chk("d4_run_gate", 32'(d4_run_ready), 32'd0);
            if (d4_done) begin
                d4_done_cyc = cyc;
`ifdef CAVLC_ENC_BITCOUNT_EN
                chk("d4_block_bits", 32'(d4_block_bits), 32'(d4_exp_bits));
`endif
            end
        end
        lf = LevelValid && LevelReady;
        rf = RunValid && RunReady;
        af = BlockValid && BlockAccept;
        if (af) begin
            acc_cnt++;
            acc_cyc = cyc;
            if (BlockDone) b2b_hits++;
        end
        @(posedge Clk);
        #1;
        if (lf) lvl_i++;
        if (rf) run_i++;
        drive_src();
        if (af && !hold_bv) BlockValid = 1'b0;
        if (toggle) PackReady = ~PackReady;
        cyc++;
    endtask

    task automatic push_word(input logic [15:0] b, input logic [4:0] l);
        if (l != 5'd0) begin
            exp_q.push_back('{bits: b, len: l});
            exp_bits += int'(l);
        end
    endtask

    // Load a block's inputs and sources and queue the expected writes.
    task automatic start_block(input vec_t v);
        int t1c;
        TotalCoeff     = v.tc;
        TrailingOnes   = v.t1;
        TotalZeros     = v.tz;
        T1Signs        = v.signs;
        CoeffTokenBits = v.ct_bits;
        CoeffTokenLen  = v.ct_len;
        TotalZerosBits = v.tz_bits;
        TotalZerosLen  = v.tz_len;
        lvl_n = v.n_lvl; lvl_i = 0;
        run_n = v.n_run; run_i = 0;
        for (int i = 0; i < 24; i++) begin
            lvl_w[i] = '{bits: 16'(16'h0040 + i), len: 5'd8};
            run_w[i] = '{bits: 16'(i + 1), len: 5'd4};
        end
        drive_src();
        exp_bits = 0;
        t1c = (int'(v.t1) > int'(v.tc)) ? int'(v.tc) : int'(v.t1);
        push_word(v.ct_bits, v.ct_len);
        if (v.tc != 5'd0) begin
            if (t1c > 0) push_word(16'(v.signs & 3'((1 << t1c) - 1)), 5'(t1c));
            if (int'(v.tc) > t1c) for (int i = 0; i < v.n_lvl; i++) push_word(lvl_w[i].bits, lvl_w[i].len);
            if (v.tc < 5'd16) begin
                push_word(v.tz_bits, v.tz_len);
                if (v.tz != 4'd0 && v.tc > 5'd1)
                    for (int i = 0; i < v.n_run; i++) push_word(run_w[i].bits, run_w[i].len);
            end
        end
        lvl_seen   = 0;
        run_seen   = 0;
        BlockValid = 1'b1;
    endtask

    task automatic run_block(input string name, input vec_t v, input bit tog);
        int d0, h0, n;
        d0 = done_cnt; h0 = hs_cnt;
        toggle = tog;
        start_block(v);
        n = 0;
        while (done_cnt == d0 && n < 300) begin tick(); n++; end
        toggle = 1'b0;
        PackReady = 1'b1;
        if (v.exp_lat >= 0) chk({name, "_latency"}, 32'(done_cyc - acc_cyc), 32'(v.exp_lat));
        chk({name, "_words"}, 32'(hs_cnt - h0), 32'(v.exp_words));
        chk({name, "_level_state"}, 32'(lvl_seen != 0), 32'(v.exp_lvl));
        chk({name, "_run_state"}, 32'(run_seen != 0), 32'(v.exp_run));
        tick(); tick();
        chk({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        tick(); tick();
        nReset = 1'b1;
        exp_q.delete();
        d4_q.delete();
        stall_v = 1'b0;
    endtask

    initial begin
        vec_t v;
        int a0, d0, n;
        // tc t1 tz signs ct_bits ct_len tz_bits tz_len nlvl nrun words lat lvl run
        tbl[0] = '{5'd0,  2'd0, 4'd0, 3'b000, 16'h0001, 5'd1, 16'h0000, 5'd2, 0,  0, 1,  2,  0, 0};
        tbl[1] = '{5'd3,  2'd3, 4'd0, 3'b101, 16'h0003, 5'd6, 16'h0001, 5'd1, 0,  0, 3,  4,  0, 0};
        tbl[2] = '{5'd16, 2'd3, 4'd0, 3'b010, 16'h000B, 5'd9, 16'h0001, 5'd2, 13, 0, 15, 16, 1, 0};
        tbl[3] = '{5'd2,  2'd3, 4'd3, 3'b111, 16'h0005, 5'd4, 16'h0006, 5'd3, 0,  1, 4,  5,  0, 1};
        tbl[4] = '{5'd1,  2'd0, 4'd5, 3'b000, 16'h0001, 5'd2, 16'h0000, 5'd0, 1,  0, 2,  4,  1, 0};
        tbl[5] = '{5'd4,  2'd1, 4'd2, 3'b001, 16'h0007, 5'd5, 16'h0002, 5'd3, 3,  2, 8,  9,  1, 1};

        nReset = 1'b0; BlockValid = 1'b0; PackReady = 1'b1;
        TotalCoeff = 5'd0; TrailingOnes = 2'd0; TotalZeros = 4'd0; T1Signs = 3'd0;
        CoeffTokenBits = 16'd0; CoeffTokenLen = 5'd0; TotalZerosBits = 16'd0; TotalZerosLen = 5'd0;
        lvl_n = 0; lvl_i = 0; run_n = 0; run_i = 0;
        for (int i = 0; i < 24; i++) begin lvl_w[i] = '0; run_w[i] = '0; end
        drive_src();
        cyc = 0; hs_cnt = 0; done_cnt = 0; acc_cnt = 0; acc_cyc = 0; done_cyc = 0;
        lvl_seen = 0; run_seen = 0; b2b_hits = 0; d4_hs_cnt = 0; d4_done_cyc = 0;
        exp_bits = 0; d4_exp_bits = 0;
        hold_bv = 1'b0; toggle = 1'b0; d4_chk_en = 1'b0; stall_v = 1'b0;
        stall_bits = 16'd0; stall_len = 5'd0;

        // Reset state
        tick(); tick();
        chk("rst_accept", 32'(BlockAccept), 32'd1);
        chk("rst_pack_valid", 32'(PackValid), 32'd0);
        chk("rst_pack_len", 32'(PackLen), 32'd0);
        chk("rst_done", 32'(BlockDone), 32'd0);
        chk("rst_level_ready", 32'(LevelReady), 32'd0);
        chk("rst_run_ready", 32'(RunReady), 32'd0);
        chk("rst_enables", 32'({LevelEncodeEnable, RunEncodeEnable}), 32'd0);
`ifdef CAVLC_ENC_BITCOUNT_EN
        chk("rst_block_bits", 32'(BlockBits), 32'd0);
`endif
        nReset = 1'b1;
        tick();

        // Table-driven single blocks, packer always ready
        for (int i = 0; i < 6; i++) run_block($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Packer stalling every other cycle: order and stability of held words
        v = '{5'd5, 2'd1, 4'd4, 3'b001, 16'h0005, 5'd7, 16'h0003, 5'd4, 4, 3, 10, -1, 1, 1};
        PackReady = 1'b0;
        run_block("stall", v, 1'b1);

        // Back-to-back blocks with BlockValid held high
        v = '{5'd0, 2'd0, 4'd0, 3'b000, 16'h0002, 5'd2, 16'h0000, 5'd1, 0, 0, 1, 2, 0, 0};
        a0 = acc_cnt; d0 = done_cnt; b2b_hits = 0;
        hold_bv = 1'b1;
        start_block(v);
        push_word(16'h0002, 5'd2);
        exp_bits = 2;
        n = 0;
        while (acc_cnt < a0 + 2 && n < 50) begin
            tick(); n++;
            if (acc_cnt == a0 + 1 && n == 1) d0 = d0 + 0;
        end
        hold_bv = 1'b0;
        BlockValid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("b2b_accept_in_done", 32'(b2b_hits), 32'd1);
        n = 0;
        while (done_cnt < d0 + 2 && n < 50) begin tick(); n++; end
        tick();
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // MAX_COEFF=4 instance with TotalCoeff=4 skips total_zeros
        do_reset();
        chk("d4_rst_accept", 32'(d4_accept), 32'd1);
        v = '{5'd4, 2'd0, 4'd0, 3'b000, 16'h0002, 5'd3, 16'h0001, 5'd2, 4, 0, 6, 7, 1, 0};
        d4_q.push_back('{bits: 16'h0002, len: 5'd3});
        for (int i = 0; i < 4; i++) d4_q.push_back('{bits: 16'(16'h0040 + i), len: 5'd8});
        d4_exp_bits = 35;
        d4_hs_cnt = 0; d4_done_cyc = -100;
        d4_chk_en = 1'b1;
        run_block("max16_tc4", v, 1'b0);
        d4_chk_en = 1'b0;
        chk("d4_words", 32'(d4_hs_cnt), 32'd5);
        chk("d4_latency", 32'(d4_done_cyc - acc_cyc), 32'd6);
        chk("d4_queue_empty", 32'(d4_q.size()), 32'd0);

        // Reset while waiting in LEVEL_ENC, then a fresh block
        v = '{5'd5, 2'd0, 4'd0, 3'b000, 16'h0001, 5'd1, 16'h0000, 5'd1, 0, 0, 1, -1, 1, 0};
        start_block(v);
        n = 0;
        while (lvl_seen == 0 && n < 20) begin tick(); n++; end
        chk("abort_reached_level", 32'(LevelEncodeEnable), 32'd1);
        nReset = 1'b0;
        #2;
        chk("abort_pack_valid", 32'(PackValid), 32'd0);
        chk("abort_accept", 32'(BlockAccept), 32'd1);
        chk("abort_level_en", 32'(LevelEncodeEnable), 32'd0);
        chk("abort_done", 32'(BlockDone), 32'd0);
        tick();
        nReset = 1'b1;
        exp_q.delete();
        stall_v = 1'b0;
        tick();
        chk("abort_idle_accept", 32'(BlockAccept), 32'd1);
        run_block("after_abort", tbl[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
